// File: rtl/ul_seq.sv
// Registered WIDTH-bit logic/arithmetic unit with serial shift/rotate.
// Logic and arithmetic ops finish in one cycle; shift/rotate step one bit per clock.
module ul_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] Out,
    output logic             zero,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rot_q, rot_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;

    logic [CW-1:0]    n;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] one_res, step;
    logic             one_c;

    assign n    = B[CW-1:0];
    assign sum  = {1'b0, A} + {1'b0, B};
    // Zero-extended subtraction: the top bit is the unsigned borrow (A < B).
    assign diff = {1'b0, A} - {1'b0, B};
    assign step = rot_q ? {work_q[0], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};

    always_comb begin
        one_res = '0;
        one_c   = 1'b0;
        case (S)
            3'b000:  one_res = A & B;
            3'b001:  one_res = A | B;
            3'b010:  one_res = A ^ B;
            3'b011:  one_res = ~A;
            3'b100: begin
                one_res = sum[WIDTH-1:0];
                one_c   = sum[WIDTH];
            end
            3'b101: begin
                one_res = diff[WIDTH-1:0];
                one_c   = diff[WIDTH];
            end
            default: one_res = A;  // shift/rotate by zero
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        out_d   = out_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (S[2:1] == 2'b11 && n != '0) begin
                        state_d = StExec;
                        work_d  = A;
                        cnt_d   = n;
                        rot_d   = S[0];
                    end else begin
                        state_d = StDone;
                        out_d   = one_res;
                        zero_d  = (one_res == '0);
                        cout_d  = one_c;
                    end
                end
            end
            StExec: begin
                work_d = step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                    out_d   = step;
                    zero_d  = (step == '0);
                    cout_d  = rot_q ? 1'b0 : work_q[WIDTH-1];
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            rot_q   <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
        end
    end

    assign Out  = out_q;
    assign zero = zero_q;
    assign cout = cout_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
endmodule

// File: tb/tb_ul_seq.sv
// Scoreboard bench for ul_seq: directed WIDTH=4 cases and randomised WIDTH=8 traffic.
module tb_ul_seq;
    typedef struct {
        logic [7:0]  out;
        logic        zero;
        logic        cout;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q4[$];
    exp_t q8[$];

    logic       rst4, start4, zero4, cout4, busy4, done4;
    logic [3:0] a4, b4, out4;
    logic [2:0] s4;
    logic       rst8, start8, zero8, cout8, busy8, done8;
    logic [7:0] a8, b8, out8;
    logic [2:0] s8;

    ul_seq #(.WIDTH(4)) u4 (
        .clk(clk), .reset(rst4), .start(start4), .A(a4), .B(b4), .S(s4),
        .Out(out4), .zero(zero4), .cout(cout4), .busy(busy4), .done(done4)
    );

    ul_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst8), .start(start8), .A(a8), .B(b8), .S(s8),
        .Out(out8), .zero(zero8), .cout(cout8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: result straight from the operation definitions.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] s, input int unsigned now);
        exp_t        e;
        int unsigned ai = a, bi = b, n = b[2:0], r = 0, c = 0;
        case (s)
            3'd0: r = ai & bi;
            3'd1: r = ai | bi;
            3'd2: r = ai ^ bi;
            3'd3: r = (~ai) & 255;
            3'd4: begin r = ai + bi; c = r >> 8; r = r & 255; end
            3'd5: begin r = (ai - bi) & 255; c = (ai < bi) ? 1 : 0; end
            3'd6: begin
                r = (ai << n) & 255;
                c = (n == 0) ? 0 : ((ai >> (8 - n)) & 1);
            end
            default: r = (n == 0) ? ai : (((ai >> n) | (ai << (8 - n))) & 255);
        endcase
        e.out  = r[7:0];
        e.zero = (r == 0);
        e.cout = c[0];
        e.due  = now + 1 + ((s >= 3'd6) ? n : 0);
        return e;
    endfunction

    // Monitors: pop one expectation per done pulse; outputs must hold otherwise.
    logic [3:0] last4 = '0;
    logic       prev_done4 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst4) begin
            last4      = out4;
            prev_done4 = 1'b0;
        end else begin
            if (done4) begin
                chk("u4 done_width", {31'd0, prev_done4}, 0);
                chk("u4 busy_at_done", {31'd0, busy4}, 1);
                if (q4.size() == 0) begin
                    chk("u4 unexpected_done", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk("u4 out", {28'd0, out4}, {24'd0, e.out});
                    chk("u4 zero", {31'd0, zero4}, {31'd0, e.zero});
                    chk("u4 cout", {31'd0, cout4}, {31'd0, e.cout});
                    chk("u4 latency", cyc, e.due);
                end
            end else if (out4 != last4) begin
                chk("u4 out_hold", {28'd0, out4}, {28'd0, last4});
            end
            last4      = out4;
            prev_done4 = done4;
        end
    end

    logic [7:0] last8 = '0;
    logic       prev_done8 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst8) begin
            last8      = out8;
            prev_done8 = 1'b0;
        end else begin
            if (done8) begin
                chk("u8 done_width", {31'd0, prev_done8}, 0);
                if (q8.size() == 0) begin
                    chk("u8 unexpected_done", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("u8 out", {24'd0, out8}, {24'd0, e.out});
                    chk("u8 zero", {31'd0, zero8}, {31'd0, e.zero});
                    chk("u8 cout", {31'd0, cout8}, {31'd0, e.cout});
                    chk("u8 latency", cyc, e.due);
                end
            end else if (out8 != last8) begin
                chk("u8 out_hold", {24'd0, out8}, {24'd0, last8});
            end
            last8      = out8;
            prev_done8 = done8;
        end
    end

    task automatic wait4();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q4.size() == 0 && !busy4) return;
        end
        chk("u4 timeout", 1, 0);
        q4.delete();
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                          input logic [3:0] eo, input logic ez, input logic ec,
                          input int unsigned lat_n);
        exp_t e;
        wait4();
        a4 = a; b4 = b; s4 = s; start4 = 1'b1;
        e.out = {4'd0, eo}; e.zero = ez; e.cout = ec; e.due = cyc + 1 + lat_n;
        q4.push_back(e);
        @(negedge clk);
        #1;
        start4 = 1'b0;
        a4 = $urandom; b4 = $urandom; s4 = $urandom;
    endtask

    task automatic wait8();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q8.size() == 0 && !busy8) begin
                start8 = 1'b0;
                return;
            end
            // Junk start while busy must be ignored.
            start8 = busy8 ? 1'($urandom_range(1)) : 1'b0;
            a8 = $urandom; b8 = $urandom; s8 = $urandom;
        end
        chk("u8 timeout", 1, 0);
        q8.delete();
        start8 = 1'b0;
    endtask

    task automatic issue8();
        wait8();
        if ($urandom_range(3) == 0) begin
            @(negedge clk);
            #1;
        end
        a8 = $urandom; b8 = $urandom; s8 = $urandom;
        start8 = 1'b1;
        q8.push_back(model8(a8, b8, s8, cyc));
    endtask

    initial begin
        rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; s4 = '0; a8 = '0; b8 = '0; s8 = '0;
        repeat (3) @(negedge clk);
        chk("rst out4", {28'd0, out4}, 0);
        chk("rst flags4", {28'd0, zero4, cout4, busy4, done4}, 0);
        chk("rst out8", {24'd0, out8}, 0);
        chk("rst flags8", {28'd0, zero8, cout8, busy8, done8}, 0);
        #1;
        rst4 = 1'b0; rst8 = 1'b0;

        issue4(4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0, 1'b0, 0);
        issue4(4'b1111, 4'b0001, 3'b100, 4'b0000, 1'b1, 1'b1, 0);
        issue4(4'b0011, 4'b0101, 3'b101, 4'b1110, 1'b0, 1'b1, 0);
        issue4(4'b1011, 4'b0010, 3'b110, 4'b1100, 1'b0, 1'b0, 2);
        issue4(4'b0001, 4'b0011, 3'b111, 4'b0010, 1'b0, 1'b0, 3);
        issue4(4'b0001, 4'b0000, 3'b111, 4'b0001, 1'b0, 1'b0, 0);
        issue4(4'b1001, 4'b0110, 3'b011, 4'b0110, 1'b0, 1'b0, 0);
        issue4(4'b1001, 4'b0110, 3'b001, 4'b1111, 1'b0, 1'b0, 0);
        issue4(4'b1001, 4'b1001, 3'b010, 4'b0000, 1'b1, 1'b0, 0);
        issue4(4'b1001, 4'b0001, 3'b110, 4'b0010, 1'b0, 1'b1, 1);
        issue4(4'b0110, 4'b0011, 3'b110, 4'b0000, 1'b1, 1'b1, 3);

        // Start pulsed during EXEC/DONE with different operands is ignored.
        issue4(4'b1011, 4'b0010, 3'b110, 4'b1100, 1'b0, 1'b0, 2);
        start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; s4 = 3'b000;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        start4 = 1'b0;
        wait4();

        // Reset in the middle of a rotate aborts it with no done pulse.
        issue4(4'b0001, 4'b0011, 3'b111, 4'b0010, 1'b0, 1'b0, 3);
        @(posedge clk);
        #2;
        rst4 = 1'b1;
        #1;
        chk("midrst out4", {28'd0, out4}, 0);
        chk("midrst flags4", {28'd0, zero4, cout4, busy4, done4}, 0);
        q4.delete();
        @(negedge clk);
        #1;
        rst4 = 1'b0;
        issue4(4'b0110, 4'b0011, 3'b100, 4'b1001, 1'b0, 1'b0, 0);
        issue4(4'b0110, 4'b0001, 3'b111, 4'b0011, 1'b0, 1'b0, 1);
        wait4();

        for (int i = 0; i < 1200; i++) issue8();
        wait8();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
